// File: rtl/smac_pkg.sv
// smac_pkg: shared widths, FSM states and arithmetic helpers for smac_accum.
package smac_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int SAT_W  = 64;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    // Signed w-bit extreme in the direction of the overflow, sign-extended to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_clamp(input logic neg, input int w);
        logic [SAT_W-1:0] mx;
        mx = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        return neg ? $signed(~mx) : $signed(mx);
    endfunction
endpackage

// File: rtl/smac_accum_if.sv
// smac_accum_if: operand-in and result-out valid/ready handshakes for smac_accum.
interface smac_accum_if
    import smac_pkg::*;
#(
    parameter int ACC_W = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OP_W-1:0]  a;
    logic signed [OP_W-1:0]  b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;

    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, acc, ovf);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, acc, ovf);
endinterface

// File: rtl/smult8bit.sv
// smult8bit: 8x8 signed multiplier with a full 16-bit product.
module smult8bit (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);
    assign p = a * b;
endmodule

// File: rtl/smac_accum.sv
// smac_accum: streaming signed 8x8 multiply-accumulate, one dot product per N_TERMS pairs.
// Define SMAC_SAT_EN to clamp acc on overflow instead of wrapping.
module smac_accum
    import smac_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    smac_accum_if.slave bus
);
    localparam int CW = $clog2(N_TERMS + 1);

    if (ACC_W < PROD_W || ACC_W > SAT_W) begin : g_acc_w_chk
        $error("smac_accum: ACC_W must be in 16..64");
    end
    if (N_TERMS < 1 || N_TERMS > 256) begin : g_n_terms_chk
        $error("smac_accum: N_TERMS must be in 1..256");
    end

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [OP_W-1:0]  op_a_q, op_b_q;
    logic                    op_v_q, op_first_q, take, done_hs;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_x, sum;
    logic                    ovf_q, ovf_d, add_o;

    smult8bit u_mult (.a(op_a_q), .b(op_b_q), .p(prod));

    assign bus.in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign bus.out_valid = state_q == DONE;
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign take          = bus.in_valid && bus.in_ready && !clear;
    assign done_hs       = (state_q == DONE) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (take) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == CW'(N_TERMS)) ? DRAIN : ACCUM;
        end
        if (state_q == DRAIN) state_d = DONE;
        if (done_hs || clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign prod_x = ACC_W'(prod);
    assign sum    = acc_q + prod_x;
    assign add_o  = op_v_q && !op_first_q && add_ovf(acc_q[ACC_W-1], prod_x[ACC_W-1], sum[ACC_W-1]);

    // clear keeps acc; the next first term overwrites it.
`ifdef SMAC_SAT_EN
    logic signed [SAT_W-1:0] sat_v;
    assign sat_v = sat_clamp(prod_x[ACC_W-1], ACC_W);
    assign acc_d = (clear || !op_v_q) ? acc_q : op_first_q ? prod_x : add_o ? sat_v[ACC_W-1:0] : sum;
`else
    assign acc_d = (clear || !op_v_q) ? acc_q : op_first_q ? prod_x : sum;
`endif

    assign ovf_d = !(done_hs || clear) && (ovf_q || add_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_v_q     <= 1'b0;
            op_first_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_v_q  <= take;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            if (take) begin
                op_a_q     <= bus.a;
                op_b_q     <= bus.b;
                op_first_q <= state_q == IDLE;
            end
        end
    end
endmodule

// File: tb/tb_smac_accum.sv
// tb_smac_accum: scoreboard bench for smac_accum (24-bit main instance, 16-bit overflow instance).
module tb_smac_accum;
    localparam int     ACC_W = 24;
    localparam longint MX    = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MN    = -MX - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    smac_accum_if #(.ACC_W(ACC_W)) b0 ();
    smac_accum_if #(.ACC_W(16))    b1 ();

    smac_accum #(.N_TERMS(4), .ACC_W(ACC_W)) u0 (.clk(clk), .rst(rst), .clear(clear), .bus(b0));
    smac_accum #(.N_TERMS(4), .ACC_W(16))    u1 (.clk(clk), .rst(rst), .clear(clear), .bus(b1));

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        logic   ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail = 0;
    longint m_acc;
    logic   m_ovf, m_first;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_ovf   = 1'b0;
    endtask

    // Range-based reference: exact sum checked against the signed ACC_W bounds.
    task automatic send(input int a, input int b, input int gap);
        longint s;
        bit     hs;
        hs = 1'b0;
        s  = longint'(a * b);
        if (m_first) m_acc = s;
        else begin
            s = m_acc + s;
            if (s > MX || s < MN) begin
                m_ovf = 1'b1;
`ifdef SMAC_SAT_EN
                m_acc = (s > MX) ? MX : MN;
`else
                m_acc = (s > MX) ? s - (MX - MN + 1) : s + (MX - MN + 1);
`endif
            end else m_acc = s;
        end
        m_first    = 1'b0;
        b0.in_valid = 1'b1;
        b0.a        = 8'(a);
        b0.b        = 8'(b);
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = b0.in_ready;
            @(posedge clk);
            #1;
        end
        b0.in_valid = 1'b0;
        if (!hs) chk("hs_timeout", 0, 1);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp();
        sb.push_back('{m_acc, m_ovf});
        model_reset();
    endtask

    task automatic get_result(input string tag, output int waited, output longint got);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        waited = 0;
        got    = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            waited++;
            seen = b0.out_valid;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        else if (sb.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
        else begin
            e   = sb.pop_front();
            got = b0.acc;
            chk({tag, "_acc"}, b0.acc, e.acc);
            chk({tag, "_ovf"}, b0.ovf, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic basic_vec();
        send(-103, 1, 0);
        send(126, -1, 0);
        send(-11, 120, 0);
        send(-127, -127, 0);
        push_exp();
    endtask

    initial begin
        int     w;
        longint g;
        bit     seen;
        b0.in_valid = 1'b0; b0.a = '0; b0.b = '0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", b0.in_ready, 1);
        chk("rst_out_valid", b0.out_valid, 0);
        chk("rst_acc", b0.acc, 0);
        chk("rst_ovf", b0.ovf, 0);
        @(posedge clk);
        #1;

        basic_vec();
        get_result("basic", w, g);
        chk("basic_lat", w, 2);
        chk("basic_val", g, 14580);

        send(-90, 90, 2);
        send(1, 1, 2);
        send(122, 57, 2);
        send(125, -113, 0);
        push_exp();
        get_result("gaps", w, g);
        chk("gaps_lat", w, 2);
        chk("gaps_val", g, -15270);

        // Backpressure: hold DONE for 3 cycles while offering a term that must be refused.
        b0.out_ready = 1'b0;
        basic_vec();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b0.out_valid;
        end
        chk("bp_seen", seen, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", b0.out_valid, 1);
            chk("bp_in_ready", b0.in_ready, 0);
            chk("bp_acc", b0.acc, sb[0].acc);
            chk("bp_ovf", b0.ovf, sb[0].ovf);
            b0.in_valid = 1'b1;
            b0.a = 8'sd9;
            b0.b = 8'sd9;
        end
        @(posedge clk);
        #1;
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        get_result("bp", w, g);
        chk("bp_val", g, 14580);
        @(negedge clk);
        chk("bp_idle_valid", b0.out_valid, 0);
        chk("bp_idle_ready", b0.in_ready, 1);
        @(posedge clk);
        #1;

        // Abort after two terms; the term offered alongside clear is dropped.
        send(5, 5, 0);
        send(7, 7, 0);
        b0.in_valid = 1'b1; b0.a = 8'sd50; b0.b = 8'sd50; clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        b0.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_ready", b0.in_ready, 1);
        chk("abort_valid", b0.out_valid, 0);
        chk("abort_ovf", b0.ovf, 0);
        @(posedge clk);
        #1;
        basic_vec();
        get_result("abort", w, g);
        chk("abort_val", g, 14580);

        // Reset after three terms.
        send(3, 4, 0);
        send(3, 4, 0);
        send(3, 4, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mrst_in_ready", b0.in_ready, 1);
        chk("mrst_out_valid", b0.out_valid, 0);
        chk("mrst_acc", b0.acc, 0);
        chk("mrst_ovf", b0.ovf, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        push_exp();
        get_result("mrst", w, g);
        chk("mrst_val", g, 4);

        for (int v = 0; v < 3; v++) begin
            for (int t = 0; t < 4; t++)
                send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                     (t < 3) ? int'($urandom_range(2)) : 0);
            push_exp();
            get_result("rnd", w, g);
        end
        chk("sb_drained", sb.size(), 0);

        // 16-bit instance: four (-128,-128) terms overflow.
        b1.in_valid = 1'b1;
        b1.a = -8'sd128;
        b1.b = -8'sd128;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ovf_in_ready", b1.in_ready, 1);
            @(posedge clk);
            #1;
        end
        b1.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b1.out_valid;
        end
        chk("ovf_seen", seen, 1);
        chk("ovf_flag", b1.ovf, 1);
`ifdef SMAC_SAT_EN
        chk("ovf_acc", b1.acc, 32767);
`else
        chk("ovf_acc", b1.acc, 0);
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovf_cleared", b1.ovf, 0);
        chk("ovf_idle_valid", b1.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/smac_accum.md
Name: smac_accum

Overview:
- Sequential multiply-accumulate stage that sits directly downstream of the 8-bit signed array multiplier `smult8bit`.
- Accepts a stream of signed 8-bit operand pairs over a valid/ready handshake and forms each 16-bit signed product through an instance of `smult8bit`.
- Accumulates N_TERMS products into a wide signed sum and presents that dot-product result over an output valid/ready handshake.

Parameters:
- N_TERMS, 4, number of operand pairs per result; range 1..256.
- ACC_W, 24, accumulator width in bits; must be >= 16. Elaboration-time error if < 16.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; discards the partial sum.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  8  signed multiplicand.
- b  in  8  signed multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- acc  out  ACC_W  signed accumulated result.
- ovf  out  1  an accumulate overflowed ACC_W during this result.

Behaviour:
- Reset: rst sampled high at a clk edge gives state=IDLE, term count=0, operand regs=0, op_v=0, acc=0, ovf=0, out_valid=0, in_ready=1.
- rst has priority over everything. Reset mid-operation drops all partial state, with no result emitted.
- A term is accepted in any cycle where in_valid && in_ready.
- Stage 1: the accepted a and b are registered into op_a, op_b, and op_v is set.
- Stage 2: the `smult8bit` product of op_a and op_b is sign-extended to ACC_W and added to acc on the next edge.
  - The first term of a result loads acc with the product instead of adding to it.
- Throughput: 1 term per cycle.
- Latency: if the last handshake is in cycle k, out_valid=1 and the final acc are visible in cycle k+2.
- States:
  - IDLE: in_ready=1. A handshake sets count=1 and goes to ACCUM, or to DRAIN if N_TERMS=1.
  - ACCUM: in_ready=1. Each handshake increments count. The handshake that makes count=N_TERMS goes to DRAIN.
  - DRAIN: in_ready=0. Adds the last product, then goes to DONE.
  - DONE: out_valid=1, in_ready=0. acc and ovf are held stable while out_ready=0. When out_valid && out_ready, go to IDLE, clear ovf and count, and deassert out_valid on the next cycle.
- Gaps: in_valid=0 cycles inside ACCUM are legal and do not advance count.
- clear:
  - Acts in any state; goes to IDLE, count=0, op_v=0, ovf=0, out_valid=0.
  - acc holds its old value and is overwritten by the next first term.
  - clear wins over a simultaneous in_valid handshake (the term is dropped) and over out_ready.
- Overflow: ovf goes high and stays high for the current result when any add's signed result exceeds the ACC_W range (both operand signs equal, result sign differs).
- Arithmetic: two's complement throughout. The count register is clog2(N_TERMS+1) bits wide.

Optional Feature:
- Macro: SMAC_SAT_EN.
- Defined: on overflow, acc clamps to the signed ACC_W maximum (positive overflow) or minimum (negative overflow). A clamped acc stays clamped only until a later add brings the value back in range, and that add is computed from the clamped value. ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W. ovf behaves identically in both builds.

Decomposition:
- Package `smac_pkg`:
  - constants OP_W=8 and PROD_W=16;
  - state enum {IDLE, ACCUM, DRAIN, DONE};
  - function for the signed-add overflow detection;
  - function for the saturation clamp.
- Sub-module: instance of the existing `smult8bit` (ports a, b, p). No other sub-modules.

Test Plan:
- Basic sum (N_TERMS=4, back-to-back): (-103,1), (126,-1), (-11,120), (-127,-127) -> acc=14580, ovf=0, out_valid high exactly 2 cycles after the 4th handshake.
- Mixed signs with gaps (N_TERMS=4, in_valid idle 2 cycles between terms): (-90,90), (1,1), (122,57), (125,-113) -> acc=-15270, ovf=0.
- Backpressure: out_ready=0 for 3 cycles after result -> acc, ovf and out_valid held stable, in_ready=0. A term offered during DONE is not accepted. On out_ready=1 -> IDLE next cycle.
- Overflow (ACC_W=16, N_TERMS=4): four terms (-128,-128) -> ovf=1. acc=0 without SMAC_SAT_EN; acc=32767 with SMAC_SAT_EN.
- Abort: clear asserted with in_valid=1 after 2 terms, then the full basic-sum vector -> the term offered with clear is dropped, the result is 14580, and no stale terms contribute.
- Reset mid-operation: rst after 3 terms -> every output at its reset value the next cycle. The following 4-term vector (1,1)x4 gives acc=4.
